// File: rtl/gcd_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gcd_seq_pkg: shared types and constants for the GCD job sequencer    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package gcd_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    LDA  = 3'd2,
    LDB  = 3'd3,
    RUN  = 3'd4,
    OUT  = 3'd5
  } state_t;

  localparam int DEFAULT_W              = 16;
  localparam int DEFAULT_TIMEOUT_CYCLES = 70000;

  function automatic int cnt_width(input int timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gcd_job_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gcd_job_sequencer: operand-pair front end for the subtractive GCD    |
// | core, with zero-operand bypass and a RUN watchdog. Rev 1.0           |
// +----------------------------------------------------------------------+
module gcd_job_sequencer
  import gcd_seq_pkg::*;
#(
  parameter int W              = DEFAULT_W,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_result,
  output logic         out_err,
  input  logic         out_ready,
  output logic         core_rst,
  output logic         core_start,
  output logic [W-1:0] core_data_in,
  input  logic         core_done,
  input  logic [W-1:0] core_result
);

  localparam int            CW       = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic [CW-1:0] cnt;

  // The core's final state is absorbing, so every job starts with a core reset.
  assign core_rst = rst | (state == CLR);

  // Handshake flags are set alongside the state transition so they track the
  // state register without any combinational path from the inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_err      <= 1'b0;
      core_start   <= 1'b0;
      core_data_in <= '0;
      cnt          <= '0;
      op_a         <= '0;
      op_b         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            op_a     <= in_a;
            op_b     <= in_b;
            in_ready <= 1'b0;
            // Zero operands would hang the subtractive core; resolve locally.
            if (in_a == '0 || in_b == '0) begin
              out_result <= in_a | in_b;
              out_err    <= 1'b0;
              out_valid  <= 1'b1;
              state      <= OUT;
            end else begin
              state <= CLR;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        CLR: begin
          core_start   <= 1'b1;
          core_data_in <= op_a;
          state        <= LDA;
        end
        LDA: begin
          core_start   <= 1'b0;
          core_data_in <= op_b;
          state        <= LDB;
        end
        LDB: begin
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          if (core_done) begin
            out_result <= core_result;
            out_err    <= 1'b0;
            out_valid  <= 1'b1;
            state      <= OUT;
          end else if (cnt == CNT_LAST) begin
            out_result <= '0;
            out_err    <= 1'b1;
            out_valid  <= 1'b1;
            state      <= OUT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/gcd_job_sequencer.md
# gcd_job_sequencer

Front-end sequencer that sits directly upstream of the GCD core (controller FSM plus subtract/compare datapath). It accepts operand pairs over a valid/ready handshake and resolves zero operands locally. For all other pairs it re-initialises the core, presents A then B on the core's shared `data_in` bus with `start`, and waits for `done`. It then returns the result over a valid/ready output handshake, with a watchdog that flags a hung core.

## Interface
- `W`, 16, operand/result width
- `TIMEOUT_CYCLES`, 70000, maximum cycles to wait in RUN for `core_done`; must exceed 2^W + 4
- `clk` in 1: sole clock, rising edge
- `rst` in 1: reset, synchronous, active-high
- `in_valid` in 1: operand pair valid
- `in_a` in W: operand A
- `in_b` in W: operand B
- `in_ready` out 1: sequencer can accept a pair
- `out_valid` out 1: result valid
- `out_result` out W: GCD result
- `out_err` out 1: result invalid because the watchdog expired
- `out_ready` in 1: consumer accepts the result
- `core_rst` out 1: synchronous, active-high reset to the core controller's state register
- `core_start` out 1: core `start`
- `core_data_in` out W: core `data_in`, muxed onto A/B by the core's `sel_in`
- `core_done` in 1: core `done`
- `core_result` in W: core A register, which holds the GCD when `done`=1

## Operation
- States: IDLE, CLR, LDA, LDB, RUN, OUT.
- IDLE
  - `in_ready`=1.
  - On `in_valid`&`in_ready`, latch `in_a`/`in_b`.
  - If either operand is 0: result = `in_a | in_b` (so 0,0 gives 0), `out_err`=0, go to OUT. The core is never started, because zero operands hang the subtractive core.
  - Otherwise go to CLR.
- CLR: `core_rst`=1 for one cycle, forcing the core to its load-A state. This is required because the core's final state is absorbing. Next state LDA.
- LDA: `core_start`=1, `core_data_in`=A. The core loads A at this edge. Next state LDB.
- LDB: `core_start`=0, `core_data_in`=B. The core loads B at this edge. Next state RUN; the watchdog counter clears to 0.
- RUN
  - `core_data_in`=B (held); the counter increments each cycle.
  - On `core_done`=1: capture `core_result`, `out_err`=0, go to OUT.
  - Else if counter = `TIMEOUT_CYCLES`-1: result=0, `out_err`=1, go to OUT.
  - `core_done` takes priority if both conditions occur in the same cycle.
- OUT
  - `out_valid`=1; `out_result` and `out_err` are held stable.
  - On `out_ready`=1 go to IDLE.
  - `in_ready`=0 (no overlap; one job in flight).
- `out_result`/`out_err` are registers. `core_start`, `in_ready` and `out_valid` decode from the state register only, with no combinational path from inputs.
- Counter width is $clog2(`TIMEOUT_CYCLES`+1).

## Timing
- Reset values: state IDLE, `in_ready`=0 while `rst`=1, `out_valid`=0, `out_result`=0, `out_err`=0, `core_start`=0, `core_data_in`=0, counter 0.
- `core_rst` = `rst` | (state==CLR), so the core is also held in reset whenever the sequencer is.
- Reset mid-operation (any state) aborts the job; no result is emitted; IDLE is reached on the first cycle after `rst` falls.
- Normal latency: acceptance edge e0, then CLR, LDA, LDB, RUN. Minimum case (A==B): `core_done` is seen in the first RUN cycle and `out_valid` rises after edge e4. Each extra core iteration adds 1 cycle.
- Bypass latency: `out_valid` rises after the acceptance edge (1 cycle).
- Next acceptance at the earliest the cycle after the `out_valid`&`out_ready` edge. Back-to-back throughput is therefore latency+1.
- `in_valid` dropping outside IDLE is ignored; operands are latched.

## Structure
- Package `gcd_seq_pkg` holds:
  - the state enum (IDLE..OUT, 3-bit encoding);
  - default `W` and `TIMEOUT_CYCLES` constants;
  - a width function for the counter.
- Single module with no sub-modules. The watchdog counter is inline, as it is only used in RUN.

## Test plan
- A=48, B=18 with a behavioural core model, `out_ready`=1 → `out_result`=6, `out_err`=0; `core_start` high for exactly 1 cycle with `core_data_in`=48, then `core_data_in`=18 the next cycle.
- A=7, B=7 → `out_valid` 4 edges after acceptance, `out_result`=7.
- A=0, B=9 → `out_result`=9 one cycle after acceptance; `core_start` and `core_rst` never asserted (post-reset). Separately, A=0, B=0 → 0.
- `out_ready` held low for 10 cycles in OUT → `out_valid`, `out_result` and `out_err` stable, `in_ready`=0 throughout; an `in_valid` pulse offered during this time is not accepted.
- `TIMEOUT_CYCLES`=20, core `done` stuck at 0 → `out_valid` with `out_err`=1, `out_result`=0, exactly 20 cycles after entering RUN.
- `rst` pulsed during RUN of a 100,1 job → `out_valid` never rises and `core_rst` is high during `rst`. A subsequent 12,8 job returns 4.
